data_mem_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage data accesses. The CPU drives load/store requests; this block holds the word-organised data RAM. It services one request at a time with a fixed, parameterised access latency and returns a one-cycle response. It raises STALL so the pipeline freezes until the response is delivered.

---
 rtl/data_mem_responder_if.sv | 44 ++++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Bundles the MEM-stage request/response signals between the CPU pipeline
//   (master) and the data memory responder (slave).
//
//   Request side (master -> slave):
//     REQ_VALID   request present
//     REQ_WE      1 = store, 0 = load
//     REQ_ADDR    32-bit byte address
//     REQ_WDATA   32-bit store data
//   Response side (slave -> master):
//     REQ_READY   responder can accept a request this cycle
//     RESP_VALID  one-cycle response strobe per accepted request
//     RESP_RDATA  load data (0 for stores and errors), held between responses
//     RESP_ERR    accepted request was misaligned or out of range
//     STALL       pipeline freeze request
//
//   Handshake: a request transfers on a rising clock edge where REQ_VALID and
//   REQ_READY are both 1. REQ_* are don't-care whenever REQ_READY is 0. There
//   is no backpressure on the response: RESP_VALID is high for exactly one
//   cycle and the master must capture RESP_RDATA/RESP_ERR on that edge (STALL
//   is low in that cycle so the pipeline advances).
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        REQ_VALID;
    logic        REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        REQ_READY;
    logic        RESP_VALID;
    logic [31:0] RESP_RDATA;
    logic        RESP_ERR;
    logic        STALL;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
        input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR, STALL
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
        output REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR, STALL
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Word-organised data RAM serving one MEM-stage load/store at a time with a
//   fixed access latency. A request is latched in IDLE, waits LATENCY edges in
//   WAIT (the access happens on the last of them), and is answered with a
//   single RESP cycle before returning to IDLE.
//
//   Ports:
//     CLOCK      system clock, rising edge
//     RESET      asynchronous, active-low reset
//     bus        data_mem_responder_if.slave (request/response/STALL)
//     dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
//   Parameters:
//     ADDR_W     word-address width, RAM depth = 2**ADDR_W words
//     LATENCY    WAIT cycles before the access, 1..15
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                CLOCK,
    input  logic                RESET,
    data_mem_responder_if.slave bus,
    output logic [1:0]          dbg_state
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]       mem [0:DEPTH-1];
    logic              mem_we;
    logic [ADDR_W-1:0] word_idx;
    logic              acc_err;

    // Decode of the latched request only; REQ_* never reach the response path.
    assign word_idx = addr_q[ADDR_W+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VALID) begin
                    we_d    = bus.REQ_WE;
                    addr_d  = bus.REQ_ADDR;
                    wdata_d = bus.REQ_WDATA;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Errors take the same path length as good accesses;
                    // only the RAM write and the returned data differ.
                    state_d = ST_RESP;
                    if (acc_err) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = 32'h0;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = mem[word_idx];
                        err_d   = 1'b0;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset. A reset during WAIT forces state_q to IDLE
    // immediately, so mem_we drops and the pending store is never written.
    always_ff @(posedge CLOCK) begin
        if (mem_we) begin
            mem[word_idx] <= wdata_q;
        end
    end

    assign bus.REQ_READY  = (state_q == ST_IDLE);
    assign bus.RESP_VALID = (state_q == ST_RESP);
    assign bus.RESP_RDATA = rdata_q;
    assign bus.RESP_ERR   = err_q;
    assign bus.STALL      = ((state_q == ST_IDLE) && bus.REQ_VALID) ||
                            (state_q == ST_WAIT);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders share clock and reset: dut_a (LATENCY=2) and dut_b
//   (LATENCY=1), both ADDR_W=10. Expected values come from constant tables
//   and a word-addressed associative-array memory model.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT_A  = 2;
    localparam int LAT_B  = 1;

    logic       CLOCK;
    logic       RESET;
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_A)) dut_a (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .bus       (ifa.slave),
        .dbg_state (dbg_a)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_B)) dut_b (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .bus       (ifb.slave),
        .dbg_state (dbg_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] model_mem [int];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    function automatic logic is_bad(input logic [31:0] addr);
        return ((addr % 4) != 0) || (addr >= (32'd4 << ADDR_W));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit sel, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            ifb.REQ_VALID = v; ifb.REQ_WE = we; ifb.REQ_ADDR = addr; ifb.REQ_WDATA = wdata;
        end else begin
            ifa.REQ_VALID = v; ifa.REQ_WE = we; ifa.REQ_ADDR = addr; ifa.REQ_WDATA = wdata;
        end
    endtask

    task automatic sample(input bit sel, output logic rdy, output logic vld,
                          output logic err, output logic stl, output logic [31:0] rd);
        #1;
        if (sel) begin
            rdy = ifb.REQ_READY; vld = ifb.RESP_VALID; err = ifb.RESP_ERR;
            stl = ifb.STALL; rd = ifb.RESP_RDATA;
        end else begin
            rdy = ifa.REQ_READY; vld = ifa.RESP_VALID; err = ifa.RESP_ERR;
            stl = ifa.STALL; rd = ifa.RESP_RDATA;
        end
    endtask

    // One complete transaction with cycle-exact checks. The response must
    // appear LATENCY+1 falling edges after the drive edge and last one cycle.
    task automatic do_req(input bit sel, input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input logic chk);
        logic rdy, vld, err, stl;
        logic [31:0] rd;
        int lat;
        int n;
        lat = sel ? LAT_B : LAT_A;
        @(negedge CLOCK);
        sample(sel, rdy, vld, err, stl, rd);
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge CLOCK);
            sample(sel, rdy, vld, err, stl, rd);
            n++;
        end
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        if (!rdy) return;
        drive(sel, 1'b1, we, addr, wdata);
        sample(sel, rdy, vld, err, stl, rd);
        check({tag, "_stall_req"}, 32'(stl), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLOCK);
            sample(sel, rdy, vld, err, stl, rd);
            check({tag, "_wait_valid"}, 32'(vld), 32'd0);
            check({tag, "_wait_stall"}, 32'(stl), 32'd1);
            check({tag, "_wait_ready"}, 32'(rdy), 32'd0);
            // Inputs are don't-care while busy; scramble them.
            drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        @(negedge CLOCK);
        sample(sel, rdy, vld, err, stl, rd);
        check({tag, "_resp_valid"}, 32'(vld), 32'd1);
        check({tag, "_resp_stall"}, 32'(stl), 32'd0);
        check({tag, "_resp_ready"}, 32'(rdy), 32'd0);
        check({tag, "_resp_err"}, 32'(err), 32'(exp_err));
        if (chk) check({tag, "_resp_rdata"}, rd, exp_rdata);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLOCK);
        sample(sel, rdy, vld, err, stl, rd);
        check({tag, "_post_valid"}, 32'(vld), 32'd0);
        check({tag, "_post_ready"}, 32'(rdy), 32'd1);
        check({tag, "_hold_err"}, 32'(err), 32'(exp_err));
        if (chk) check({tag, "_hold_rdata"}, rd, exp_rdata);
    endtask

    // Model-driven request on dut_a: expectation from the address rules and
    // the model memory; unwritten words skip the data comparison.
    task automatic model_req(input string tag, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        logic bad;
        logic chk;
        logic [31:0] exp;
        int key;
        bad = is_bad(addr);
        key = int'(addr / 4);
        chk = 1'b1;
        exp = 32'h0;
        if (!bad && !we) begin
            if (model_mem.exists(key)) exp = model_mem[key];
            else chk = 1'b0;
        end
        do_req(1'b0, tag, we, addr, wdata, bad, exp, chk);
        if (!bad && we) model_mem[key] = wdata;
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic rdy, vld, err, stl;
        logic [31:0] rd;
        logic [31:0] a;

        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        vecs[0] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 32'h8000_0040, 32'h5555_5555, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1234_5678};
        vecs[9] = '{1'b0, 32'h0000_0043, 32'h0,         1'b1, 32'h0};

        // Reset values
        #3;
        sample(1'b0, rdy, vld, err, stl, rd);
        check("rst_a_ready", 32'(rdy), 32'd1);
        check("rst_a_valid", 32'(vld), 32'd0);
        check("rst_a_err", 32'(err), 32'd0);
        check("rst_a_rdata", rd, 32'h0);
        check("rst_a_stall", 32'(stl), 32'd0);
        sample(1'b1, rdy, vld, err, stl, rd);
        check("rst_b_ready", 32'(rdy), 32'd1);
        check("rst_b_valid", 32'(vld), 32'd0);
        #8;
        RESET = 1'b1;

        // Table-driven vectors on dut_a
        for (int i = 0; i < 10; i++) begin
            do_req(1'b0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata, 1'b1);
            if (vecs[i].we && !vecs[i].exp_err)
                model_mem[int'(vecs[i].addr / 4)] = vecs[i].wdata;
        end

        // Reset in the middle of a store's WAIT drops the store
        model_req("pre_store", 1'b1, 32'h10, 32'h1111_1111);
        model_req("pre_load", 1'b0, 32'h40, 32'h0);
        @(negedge CLOCK);
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge CLOCK);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(1'b0, rdy, vld, err, stl, rd);
        check("midrst_in_wait", 32'(rdy), 32'd0);
        RESET = 1'b0;
        sample(1'b0, rdy, vld, err, stl, rd);
        check("midrst_rdata", rd, 32'h0);
        check("midrst_valid", 32'(vld), 32'd0);
        check("midrst_stall", 32'(stl), 32'd0);
        RESET = 1'b1;
        sample(1'b0, rdy, vld, err, stl, rd);
        check("midrst_ready_after", 32'(rdy), 32'd1);
        model_req("midrst_load", 1'b0, 32'h10, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
                1:       a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
                2:       a = {1'b1, 31'($urandom)} & 32'hFFFF_FFFC;
                default: a = 32'($urandom_range(0, 31)) * 4;
            endcase
            model_req("rand", 1'($urandom), a, $urandom);
        end

        // Back-to-back requests with REQ_VALID held high
        model_req("cont_pre0", 1'b1, 32'h100, 32'hAAAA_0100);
        model_req("cont_pre1", 1'b1, 32'h104, 32'hBBBB_0104);
        @(negedge CLOCK);
        for (int r = 0; r < 6; r++) begin
            a = (r % 2 == 0) ? 32'h100 : 32'h104;
            sample(1'b0, rdy, vld, err, stl, rd);
            check("cont_ready", 32'(rdy), 32'd1);
            drive(1'b0, 1'b1, 1'b0, a, 32'h0);
            sample(1'b0, rdy, vld, err, stl, rd);
            check("cont_stall_idle", 32'(stl), 32'd1);
            for (int k = 1; k <= LAT_A + 1; k++) begin
                @(negedge CLOCK);
                drive(1'b0, 1'b1, 1'($urandom), $urandom, $urandom);
                sample(1'b0, rdy, vld, err, stl, rd);
                check("cont_ready_busy", 32'(rdy), 32'd0);
                check("cont_valid", 32'(vld), 32'(k == LAT_A + 1));
                check("cont_stall", 32'(stl), 32'(k != LAT_A + 1));
                if (k == LAT_A + 1) begin
                    check("cont_rdata", rd, model_mem[int'(a / 4)]);
                    check("cont_err", 32'(err), 32'd0);
                end
            end
            @(negedge CLOCK);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // LATENCY=1 instance
        do_req(1'b1, "b_store", 1'b1, 32'h14, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b1);
        do_req(1'b1, "b_load", 1'b0, 32'h14, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b1);
        do_req(1'b1, "b_oor", 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, "b_mis_store", 1'b1, 32'h15, 32'h0F0F_0F0F, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, "b_reload", 1'b0, 32'h14, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
